// File: rtl/dmem_mmio_bridge.sv
// Data-memory bridge: decodes CPU dmem accesses into byte-writable RAM, a UART TX FIFO with
// status register, or unmapped space; read data is registered one cycle after the access.
module dmem_mmio_bridge #(
    parameter int unsigned RAM_WORDS  = 4096,
    parameter int unsigned CLK_DIV    = 434,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        dmem_en_i,
    input  logic [31:0] dmem_addr_i,
    input  logic [31:0] dmem_d_i,
    input  logic [3:0]  dmem_we_i,
    output logic [31:0] dmem_q_o,
    output logic        uart_tx_o
);

    localparam int unsigned AW = $clog2(RAM_WORDS);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned BW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW:0]   FifoFull = (PW + 1)'(FIFO_DEPTH);
    localparam logic [BW-1:0] BaudLast = BW'(CLK_DIV - 1);
    localparam logic [31:0]   TxDataAddr = 32'h8000_0000;
    localparam logic [31:0]   StatusAddr = 32'h8000_0004;

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} tx_state_e;

    logic [31:0] ram_mem [RAM_WORDS];
    logic [7:0]  fifo_mem [FIFO_DEPTH];

    logic [31:0]   dmem_q_q, dmem_q_d;
    logic [PW:0]   count_q, count_d;
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic          overflow_q, overflow_d;

    tx_state_e     state_q;
    logic [BW-1:0] baud_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          tx_q;

    logic          is_ram, is_txd, is_stat, stat_rd;
    logic [AW-1:0] ram_idx;
    logic          fifo_full, fifo_empty, tx_active;
    logic          push_req, push, pop;
    logic [31:0]   status, rdata;

    assign ram_idx = dmem_addr_i[AW+1:2];
    assign is_ram  = (dmem_addr_i[31:AW+2] == '0);
    assign is_txd  = (dmem_addr_i == TxDataAddr);
    assign is_stat = (dmem_addr_i == StatusAddr);
    assign stat_rd = dmem_en_i && is_stat && (dmem_we_i == 4'b0000);

    assign fifo_full  = (count_q == FifoFull);
    assign fifo_empty = (count_q == '0);
    assign tx_active  = (state_q != StIdle);
    assign status     = {28'b0, overflow_q, tx_active, fifo_empty, fifo_full};

    assign pop      = (state_q == StIdle) && !fifo_empty;
    assign push_req = dmem_en_i && is_txd && dmem_we_i[0];
    // The slot freed by a same-cycle pop can take the push even when full.
    assign push     = push_req && (!fifo_full || pop);

    always_comb begin
        rdata = '0;
        if (is_ram) begin
            rdata = ram_mem[ram_idx];
        end else if (stat_rd) begin
            rdata = status;
        end
        dmem_q_d = dmem_en_i ? rdata : dmem_q_q;
    end

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        wptr_d = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d = pop ? rptr_q + 1'b1 : rptr_q;
        overflow_d = overflow_q;
        if (push_req && !push) begin
            overflow_d = 1'b1;
        end else if (stat_rd) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            dmem_q_q   <= '0;
            count_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            dmem_q_q   <= dmem_q_d;
            count_q    <= count_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage arrays are deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (dmem_en_i && is_ram) begin
            for (int i = 0; i < 4; i++) begin
                if (dmem_we_i[i]) begin
                    ram_mem[ram_idx][8*i +: 8] <= dmem_d_i[8*i +: 8];
                end
            end
        end
        if (push) begin
            fifo_mem[wptr_q] <= dmem_d_i[7:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        shift_q <= fifo_mem[rptr_q];
                        baud_q  <= '0;
                        bit_q   <= '0;
                        tx_q    <= 1'b0;
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    if (baud_q == BaudLast) begin
                        baud_q  <= '0;
                        tx_q    <= shift_q[0];
                        state_q <= StData;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                StData: begin
                    if (baud_q == BaudLast) begin
                        baud_q  <= '0;
                        shift_q <= {1'b0, shift_q[7:1]};
                        if (bit_q == 3'd7) begin
                            bit_q   <= '0;
                            tx_q    <= 1'b1;
                            state_q <= StStop;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                            tx_q  <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                StStop: begin
                    tx_q <= 1'b1;
                    if (baud_q == BaudLast) begin
                        baud_q  <= '0;
                        state_q <= StIdle;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign dmem_q_o  = dmem_q_q;
    assign uart_tx_o = tx_q;

endmodule
